// File: rtl/add_pkg.sv
// rtl/add_pkg.sv - shared constants and parameter checks for the pipelined adder
//
// ADD / SUB   : encoding of the SUB mode input (0 = add, 1 = subtract).
// width_ok()  : true when STAGES lies in 1..WIDTH and divides WIDTH evenly.
package add_pkg;

    localparam logic ADD = 1'b0;
    localparam logic SUB = 1'b1;

    function automatic bit width_ok(input int width, input int stages);
        return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
    endfunction

endpackage

// File: rtl/add_slice.sv
// rtl/add_slice.sv - one SEG-bit combinational carry-chain segment
//
// A, B : SEG-bit operand slices (B already inverted for subtract)
// CI   : carry into bit 0 of the segment
// S    : SEG-bit sum slice
// CO   : carry out of the segment MSB
// CM   : carry into the segment MSB (CM ^ CO is signed overflow on the top segment)
module add_slice #(
    parameter int SEG = 8
) (
    input  logic [SEG-1:0] A,
    input  logic [SEG-1:0] B,
    input  logic           CI,
    output logic [SEG-1:0] S,
    output logic           CO,
    output logic           CM
);

    logic [SEG:0]   c;
    logic [SEG-1:0] p;

    assign c[0] = CI;

    // Per bit: propagate from the LUT, MUXCY passes the incoming carry when
    // propagating and otherwise injects A (generate == A when A == B),
    // XORCY forms the sum.
    for (genvar i = 0; i < SEG; i++) begin : g_bit
        assign p[i]   = A[i] ^ B[i];
        assign c[i+1] = p[i] ? c[i] : A[i];
        assign S[i]   = p[i] ^ c[i];
    end

    assign CO = c[SEG];
    assign CM = c[SEG-1];

endmodule

// File: rtl/add_pipe_cin_cout.sv
// rtl/add_pipe_cin_cout.sv - pipelined carry-chain adder/subtractor with valid/ready
//
// CLK, ASYNCRESETN     : clock (rising edge), asynchronous active-low reset
// IN_VALID / IN_READY  : operand beat handshake (IN_READY = !OUT_VALID || OUT_READY)
// I0, I1, CIN, SUB     : operands, carry-in, mode (0 add, 1 subtract via ~I1)
// O, COUT, OVF         : result, raw MSB carry-out, signed overflow
// OUT_VALID / OUT_READY: result beat handshake
module add_pipe_cin_cout #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             CLK,
    input  logic             ASYNCRESETN,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] I0,
    input  logic [WIDTH-1:0] I1,
    input  logic             CIN,
    input  logic             SUB,
    output logic [WIDTH-1:0] O,
    output logic             COUT,
    output logic             OVF,
    output logic             OUT_VALID,
    input  logic             OUT_READY
);

    if (!add_pkg::width_ok(WIDTH, STAGES)) begin : g_param_check
        $error("add_pipe_cin_cout: STAGES must be 1..WIDTH and divide WIDTH");
    end

    localparam int SEG = WIDTH / STAGES;

    // The whole pipe moves together: it may shift whenever the output rank
    // is empty or being drained this cycle.
    logic advance;
    assign advance  = !OUT_VALID || OUT_READY;
    assign IN_READY = advance;

    logic [WIDTH-1:0] b_eff;
    assign b_eff = (SUB == add_pkg::SUB) ? ~I1 : I1;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int IW = WIDTH - k * SEG;   // operand bits not yet summed
        localparam int DW = (k + 1) * SEG;     // result bits finished after this stage

        logic [IW-1:0]  a_in;
        logic [IW-1:0]  b_in;
        logic           ci;
        logic           v_in;
        logic [SEG-1:0] s;
        logic           co;
        logic           cm;
        logic [DW-1:0]  sum_d;
        logic [DW-1:0]  sum_q;
        logic           carry_q;
        logic           valid_q;

        if (k == 0) begin : g_head
            assign a_in  = I0;
            assign b_in  = b_eff;
            assign ci    = CIN;
            assign v_in  = IN_VALID;
            assign sum_d = s;
        end else begin : g_body
            assign a_in  = g_stage[k-1].g_skew.a_q;
            assign b_in  = g_stage[k-1].g_skew.b_q;
            assign ci    = g_stage[k-1].carry_q;
            assign v_in  = g_stage[k-1].valid_q;
            assign sum_d = {s, g_stage[k-1].sum_q};
        end

        add_slice #(.SEG(SEG)) u_slice (
            .A  (a_in[SEG-1:0]),
            .B  (b_in[SEG-1:0]),
            .CI (ci),
            .S  (s),
            .CO (co),
            .CM (cm)
        );

        always_ff @(posedge CLK or negedge ASYNCRESETN) begin
            if (!ASYNCRESETN) begin
                sum_q   <= '0;
                carry_q <= 1'b0;
                valid_q <= 1'b0;
            end else if (advance) begin
                sum_q   <= sum_d;
                carry_q <= co;
                valid_q <= v_in;
            end
        end

        // Upper operand slices ride along until their segment's turn.
        if (k < STAGES - 1) begin : g_skew
            logic [IW-SEG-1:0] a_q;
            logic [IW-SEG-1:0] b_q;

            always_ff @(posedge CLK or negedge ASYNCRESETN) begin
                if (!ASYNCRESETN) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (advance) begin
                    a_q <= a_in[IW-1:SEG];
                    b_q <= b_in[IW-1:SEG];
                end
            end
        end

        // Only the top segment sees the word MSB, so only it forms OVF.
        if (k == STAGES - 1) begin : g_tail
            logic ovf_q;

            always_ff @(posedge CLK or negedge ASYNCRESETN) begin
                if (!ASYNCRESETN) begin
                    ovf_q <= 1'b0;
                end else if (advance) begin
                    ovf_q <= cm ^ co;
                end
            end
        end else begin : g_mid
            logic cm_unused;
            assign cm_unused = cm;
        end
    end

    assign O         = g_stage[STAGES-1].sum_q;
    assign COUT      = g_stage[STAGES-1].carry_q;
    assign OVF       = g_stage[STAGES-1].g_tail.ovf_q;
    assign OUT_VALID = g_stage[STAGES-1].valid_q;

endmodule

// File: tb/tb_add_pipe_cin_cout.sv
// tb/tb_add_pipe_cin_cout.sv - self-checking bench for add_pipe_cin_cout at depths 1, 4 and 32
module tb_add_pipe_cin_cout;

    typedef struct {
        logic [31:0] o;
        logic        cout;
        logic        ovf;
        int          acc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] i0 = '0;
    logic [31:0] i1 = '0;
    logic        cin = 1'b0;
    logic        sub = 1'b0;
    logic        out_ready = 1'b1;

    logic        in_ready_w [3];
    logic [31:0] o_w [3];
    logic        cout_w [3];
    logic        ovf_w [3];
    logic        ov_w [3];

    int sd [3] = '{1, 4, 32};

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    bit   lat_check = 1'b1;
    exp_t sb [3][$];

    bit          prev_stall [3];
    logic [31:0] prev_o [3];
    logic        prev_cout [3];
    logic        prev_ovf [3];
    exp_t        mon_e;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        add_pipe_cin_cout #(
            .WIDTH  (32),
            .STAGES ((g == 0) ? 1 : (g == 1) ? 4 : 32)
        ) u_dut (
            .CLK         (clk),
            .ASYNCRESETN (rst_n),
            .IN_VALID    (in_valid),
            .IN_READY    (in_ready_w[g]),
            .I0          (i0),
            .I1          (i1),
            .CIN         (cin),
            .SUB         (sub),
            .O           (o_w[g]),
            .COUT        (cout_w[g]),
            .OVF         (ovf_w[g]),
            .OUT_VALID   (ov_w[g]),
            .OUT_READY   (out_ready)
        );
    end

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic c, input logic s);
        logic [31:0] bp;
        logic [32:0] full;
        exp_t        e;
        bp     = s ? ~b : b;
        full   = {1'b0, a} + {1'b0, bp} + {32'b0, c};
        e.o    = full[31:0];
        e.cout = full[32];
        e.ovf  = (a[31] == bp[31]) && (e.o[31] != a[31]);
        e.acc  = 0;
        return e;
    endfunction

    function automatic void chk(input string name, input int d,
                                input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %0h, required %0h", name, d, act, req);
        end
    endfunction

    // Scoreboard/compare process: sampled on the falling edge, transfers
    // happen on the following rising edge.
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            for (int d = 0; d < 3; d++) prev_stall[d] = 1'b0;
        end else begin
            for (int d = 0; d < 3; d++) begin
                chk("in_ready", d, in_ready_w[d], !ov_w[d] || out_ready);
                if (prev_stall[d]) begin
                    chk("stall_valid", d, ov_w[d], 1'b1);
                    chk("stall_o", d, o_w[d], prev_o[d]);
                    chk("stall_cout", d, cout_w[d], prev_cout[d]);
                    chk("stall_ovf", d, ovf_w[d], prev_ovf[d]);
                end
                if (ov_w[d]) begin
                    if (sb[d].size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL spurious_beat dut%0d: got O=%h, required no beat", d, o_w[d]);
                    end else begin
                        mon_e = sb[d][0];
                        chk("o", d, o_w[d], mon_e.o);
                        chk("cout", d, cout_w[d], mon_e.cout);
                        chk("ovf", d, ovf_w[d], mon_e.ovf);
                        if (lat_check && out_ready) chk("latency", d, cyc - mon_e.acc, sd[d]);
                        if (out_ready) void'(sb[d].pop_front());
                    end
                end
                if (in_valid && in_ready_w[d]) begin
                    mon_e     = model(i0, i1, cin, sub);
                    mon_e.acc = cyc;
                    sb[d].push_back(mon_e);
                end
                prev_stall[d] = ov_w[d] && !out_ready;
                prev_o[d]     = o_w[d];
                prev_cout[d]  = cout_w[d];
                prev_ovf[d]   = ovf_w[d];
            end
        end
    end

    task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                         input logic c, input logic s, input logic r);
        in_valid  = v;
        i0        = a;
        i1        = b;
        cin       = c;
        sub       = s;
        out_ready = r;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, $urandom, $urandom, 1'($urandom), 1'($urandom), 1'b1);
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int n = 0; n < 100 && !done; n++) begin
            idle();
            done = (sb[0].size() == 0) && (sb[1].size() == 0) && (sb[2].size() == 0)
                && !ov_w[0] && !ov_w[1] && !ov_w[2];
        end
        n_checks++;
        if (!done) begin
            n_fail++;
            $display("FAIL drain_timeout: got %0d/%0d/%0d beats outstanding, required 0",
                     sb[0].size(), sb[1].size(), sb[2].size());
        end
    endtask

    task automatic check_reset_state();
        for (int d = 0; d < 3; d++) begin
            chk("rst_o", d, o_w[d], 32'h0);
            chk("rst_cout", d, cout_w[d], 1'b0);
            chk("rst_ovf", d, ovf_w[d], 1'b0);
            chk("rst_out_valid", d, ov_w[d], 1'b0);
            chk("rst_in_ready", d, in_ready_w[d], 1'b1);
        end
    endtask

    task automatic directed(input logic [31:0] a, input logic [31:0] b, input logic c,
                            input logic s, input logic [31:0] eo, input logic ec,
                            input logic ev);
        drive(1'b1, a, b, c, s, 1'b1);
        chk("dir_s1_valid", 0, ov_w[0], 1'b1);
        chk("dir_s1_o", 0, o_w[0], eo);
        chk("dir_s1_cout", 0, cout_w[0], ec);
        idle();
        idle();
        chk("dir_s4_early", 1, ov_w[1], 1'b0);
        idle();
        chk("dir_s4_valid", 1, ov_w[1], 1'b1);
        chk("dir_s4_o", 1, o_w[1], eo);
        chk("dir_s4_cout", 1, cout_w[1], ec);
        chk("dir_s4_ovf", 1, ovf_w[1], ev);
        drain();
    endtask

    initial begin
        exp_t m;

        // Pin the reference model with hand-computed results.
        m = model(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0);
        chk("model_add", 0, {m.o, m.cout, m.ovf}, {32'h0, 1'b1, 1'b0});
        m = model(32'h8000_0000, 32'h1, 1'b1, 1'b1);
        chk("model_sub", 0, {m.o, m.cout, m.ovf}, {32'h7FFF_FFFF, 1'b1, 1'b1});
        m = model(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0);
        chk("model_ovf", 0, {m.o, m.cout, m.ovf}, {32'h8000_0000, 1'b0, 1'b1});

        // Power-on reset.
        @(posedge clk);
        @(posedge clk);
        #1;
        check_reset_state();
        rst_n = 1'b1;

        // Directed vectors: carry ripple and both overflow directions.
        lat_check = 1'b1;
        directed(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        directed(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
        directed(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);

        // Back-to-back streaming, consumer always ready.
        for (int n = 0; n < 100; n++)
            drive(1'b1, $urandom, $urandom, 1'($urandom), 1'($urandom), 1'b1);
        drain();

        // Random valid and backpressure.
        lat_check = 1'b0;
        for (int n = 0; n < 300; n++)
            drive(1'($urandom), $urandom, $urandom, 1'($urandom), 1'($urandom),
                  1'($urandom));
        drain();

        // Reset with three beats in flight, asserted between clock edges.
        lat_check = 1'b1;
        for (int n = 0; n < 3; n++)
            drive(1'b1, $urandom, $urandom, 1'($urandom), 1'($urandom), 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_state();
        for (int d = 0; d < 3; d++) sb[d].delete();
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(1'b1, 32'h1234_5678, 32'h0FED_CBA9, 1'b1, 1'b0, 1'b1);
        idle();
        idle();
        chk("post_rst_early", 1, ov_w[1], 1'b0);
        idle();
        chk("post_rst_valid", 1, ov_w[1], 1'b1);
        chk("post_rst_o", 1, o_w[1], 32'h2222_2222);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
